// File: rtl/sa_fifo_pkg.sv
// Shared geometry and counter helper for the 128x11 single-clock FIFO controller.
package sa_fifo_pkg;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 11;
    localparam int unsigned CNT_W = 8;

    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc,
                                                 input logic             dec);
        return cnt + CNT_W'(inc) - CNT_W'(dec);
    endfunction

endpackage

// File: rtl/sa_ram_rwsp_128x11.sv
// 128x11 two-port RAM: sync write port, registered read address, output data register.
module sa_ram_rwsp_128x11
    import sa_fifo_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_di,
    input  logic          i_re,
    input  logic [AW-1:0] i_ra,
    input  logic          i_ore,
    output logic [DW-1:0] o_dout,
    input  logic [31:0]   i_pwrbus_ram_pd
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_ra;
    logic [DW-1:0] r_dout;
    logic          w_unused_pwrbus;

    // Power-bus controls belong to a real macro; the behavioural array ignores them.
    assign w_unused_pwrbus = ^i_pwrbus_ram_pd;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_di;
        end
        if (i_re) begin
            r_ra <= i_ra;
        end
        if (i_ore) begin
            r_dout <= r_mem[r_ra];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/sa_fifo_ctrl_128x11.sv
// 128-entry FIFO controller sequencing one two-port RAM with a 2-stage read pipeline.
// Optional status outputs fifo_lvl/fifo_hwm are enabled by SA_FIFO_CTRL_STATUS_EN.
module sa_fifo_ctrl_128x11
    import sa_fifo_pkg::*;
#(
    parameter logic [CNT_W-1:0] AFULL_LVL = 8'd120
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [DW-1:0]    wr_pd,
    output logic             wr_afull,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [DW-1:0]    rd_pd,
    output logic             idle,
    input  logic [31:0]      pwrbus_ram_pd
`ifdef SA_FIFO_CTRL_STATUS_EN
   ,output logic [CNT_W-1:0] fifo_lvl,
    output logic [CNT_W-1:0] fifo_hwm
`endif
);

    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CNT_W-1:0] r_ram_cnt;
    logic [CNT_W-1:0] r_unfetched;
    logic             r_s1_vld;
    logic             r_s2_vld;
    logic             r_afull;
    logic             r_idle;

    logic             w_push;
    logic             w_ore;
    logic             w_re;
    logic             w_wr_prdy;
    logic [CNT_W-1:0] w_ram_cnt_d;
    logic [CNT_W-1:0] w_unfetched_d;
    logic [CNT_W-1:0] w_occ;
    logic [CNT_W-1:0] w_occ_d;
    logic             w_s1_vld_d;
    logic             w_s2_vld_d;

    assign w_wr_prdy = (r_ram_cnt < CNT_W'(DEPTH));
    assign w_push    = wr_pvld & w_wr_prdy;
    assign w_ore     = r_s1_vld & (~r_s2_vld | rd_prdy);
    // unfetched is registered, so a fetch never races its own write
    assign w_re      = (r_unfetched != '0) & (~r_s1_vld | w_ore);

    always_comb begin
        w_ram_cnt_d   = cnt_upd(r_ram_cnt, w_push, w_ore);
        w_unfetched_d = cnt_upd(r_unfetched, w_push, w_re);
        w_s1_vld_d    = w_re | (r_s1_vld & ~w_ore);
        w_s2_vld_d    = w_ore | (r_s2_vld & ~rd_prdy);
        w_occ         = r_ram_cnt + CNT_W'(r_s2_vld);
        w_occ_d       = w_ram_cnt_d + CNT_W'(w_s2_vld_d);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_ram_cnt   <= '0;
            r_unfetched <= '0;
            r_s1_vld    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_afull     <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_re) begin
                r_rp <= r_rp + 1'b1;
            end
            r_ram_cnt   <= w_ram_cnt_d;
            r_unfetched <= w_unfetched_d;
            r_s1_vld    <= w_s1_vld_d;
            r_s2_vld    <= w_s2_vld_d;
            // flags track the occupancy the registers will hold after this edge
            r_afull     <= (w_occ_d >= AFULL_LVL);
            r_idle      <= (w_occ_d == '0);
        end
    end

    assign wr_prdy  = w_wr_prdy;
    assign wr_afull = r_afull;
    assign rd_pvld  = r_s2_vld;
    assign idle     = r_idle;

`ifdef SA_FIFO_CTRL_STATUS_EN
    logic [CNT_W-1:0] r_hwm;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_hwm <= '0;
        end else if (w_occ_d > r_hwm) begin
            r_hwm <= w_occ_d;
        end
    end

    assign fifo_lvl = w_occ;
    assign fifo_hwm = r_hwm;
`else
    logic [CNT_W-1:0] w_unused_occ;
    assign w_unused_occ = w_occ;
`endif

    sa_ram_rwsp_128x11 u_ram (
        .i_clk           (nvdla_core_clk),
        .i_we            (w_push),
        .i_wa            (r_wp),
        .i_di            (wr_pd),
        .i_re            (w_re),
        .i_ra            (r_rp),
        .i_ore           (w_ore),
        .o_dout          (rd_pd),
        .i_pwrbus_ram_pd (pwrbus_ram_pd)
    );

endmodule

// File: tb/tb_sa_fifo_ctrl_128x11.sv
// Directed bench for sa_fifo_ctrl_128x11 with a queue scoreboard on every pop.
module tb_sa_fifo_ctrl_128x11;

    logic        clk     = 1'b0;
    logic        rstn    = 1'b1;
    logic        wr_pvld = 1'b0;
    logic        rd_prdy = 1'b0;
    logic [10:0] wr_pd   = '0;
    logic [31:0] pwrbus  = '0;
    logic        wr_prdy;
    logic        wr_afull;
    logic        rd_pvld;
    logic [10:0] rd_pd;
    logic        idle;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc    = 0;
    logic [10:0] q[$];

    always #5 clk = ~clk;

    sa_fifo_ctrl_128x11 dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .wr_pvld         (wr_pvld),
        .wr_prdy         (wr_prdy),
        .wr_pd           (wr_pd),
        .wr_afull        (wr_afull),
        .rd_pvld         (rd_pvld),
        .rd_prdy         (rd_prdy),
        .rd_pd           (rd_pd),
        .idle            (idle),
        .pwrbus_ram_pd   (pwrbus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record the handshakes that the coming edge will perform, then advance one cycle.
    task automatic tick();
        logic [10:0] exp;
        if (wr_pvld && wr_prdy) begin
            q.push_back(wr_pd);
            n_acc++;
        end
        if (rd_pvld && rd_prdy) begin
            if (q.size() == 0) begin
                chk("pop_unexpected", 32'(rd_pd), 32'h7fff_ffff);
            end else begin
                exp = q.pop_front();
                chk("pop_data", 32'(rd_pd), 32'(exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit done;

        // Reset values
        #1 rstn = 1'b0;
        #1;
        chk("rst_rd_pvld", 32'(rd_pvld), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_afull", 32'(wr_afull), 0);
        chk("rst_wr_prdy", 32'(wr_prdy), 1);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wr_prdy", 32'(wr_prdy), 1);

        // Three pushes, first word out three cycles after its push
        rd_prdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 11'(i);
            if (i == 3) chk("not_early", 32'(rd_pvld), 0);
            tick();
        end
        wr_pvld = 1'b0;
        chk("lat3_vld", 32'(rd_pvld), 1);
        chk("lat3_pd", 32'(rd_pd), 32'h001);
        tick();
        chk("seq_pd2", 32'(rd_pd), 32'h002);
        tick();
        chk("seq_pd3", 32'(rd_pd), 32'h003);
        tick();
        chk("seq_done_vld", 32'(rd_pvld), 0);
        chk("seq_done_idle", 32'(idle), 1);

        // Fill with pop side stalled: 128 in RAM plus one in the output register
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        n_acc   = 0;
        for (int c = 0; c < 140; c++) begin
            wr_pd = (n_acc == 0) ? 11'h5A5 : 11'(n_acc);
            tick();
            chk("afull_track", 32'(wr_afull), 32'(n_acc >= 120));
        end
        chk("full_accepted", 32'(n_acc), 129);
        chk("full_wr_prdy", 32'(wr_prdy), 0);
        chk("full_afull", 32'(wr_afull), 1);
        chk("full_idle", 32'(idle), 0);

        // Stall: head word must stay put
        wr_pvld = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("stall_vld", 32'(rd_pvld), 1);
            chk("stall_pd", 32'(rd_pd), 32'h5A5);
        end

        // Full FIFO, pop every other cycle while pushing; pointers wrap
        wr_pvld = 1'b1;
        for (int c = 0; c < 300; c++) begin
            wr_pd   = 11'(1000 + c);
            rd_prdy = c[0];
            tick();
        end

        // Drain
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        done    = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (idle) done = 1'b1;
        end
        chk("drain_done", 32'(done), 1);
        chk("drain_q_empty", 32'(q.size()), 0);
        chk("drain_afull", 32'(wr_afull), 0);

        // Reset with 50 entries queued
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        for (int c = 0; c < 50; c++) begin
            wr_pd = 11'(300 + c);
            tick();
        end
        wr_pvld = 1'b0;
        tick();
        tick();
        tick();
        chk("q50_vld", 32'(rd_pvld), 1);
        chk("q50_idle", 32'(idle), 0);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_vld", 32'(rd_pvld), 0);
        chk("async_rst_idle", 32'(idle), 1);
        chk("async_rst_prdy", 32'(wr_prdy), 1);
        q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        rd_prdy = 1'b1;
        wr_pvld = 1'b1;
        wr_pd   = 11'h7FF;
        tick();
        wr_pvld = 1'b0;
        tick();
        tick();
        chk("post_rst_vld", 32'(rd_pvld), 1);
        chk("post_rst_pd", 32'(rd_pd), 32'h7FF);
        tick();
        chk("post_rst_sole", 32'(rd_pvld), 0);
        chk("post_rst_idle", 32'(idle), 1);

        // Streaming at one push and one pop per cycle
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            wr_pd = 11'(c);
            tick();
            if (c >= 2) begin
                chk("stream_vld", 32'(rd_pvld), 1);
                chk("stream_prdy", 32'(wr_prdy), 1);
            end
        end
        wr_pvld = 1'b0;
        done    = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (idle) done = 1'b1;
        end
        chk("stream_drain", 32'(done), 1);
        chk("stream_q_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
